dtree_seq_eval: RTL and testbench
=================================

// Module: dtree_seq_eval
// PURPOSE
//  Sequential decision-tree classifier controller. It walks a tree stored in a node ROM, one node per clock.
//  A single shared comparator replaces the fully parallel comparator tree, trading latency for area in
//  printed designs. Sits between the feature source (5 x 8-bit sensor/feature regs) and the class consumer.
//  Node ROM contents come from the tree trainer; this block only sequences it.
// PARAMETERS
//  N_FEAT     5   number of input features
//  FEAT_W     8   feature / threshold width
//  NODE_AW    8   node address width (max 256 nodes)
//  CLASS_W    1   class label width
//  MAX_DEPTH  24  walk-step limit before error abort
// PORTS
//  clk        in   1                 clock
//  rst_n      in   1                 async active-low reset
//  in_valid   in   1                 feature vector valid
//  in_ready   out  1                 block can accept a vector (IDLE only)
//  in_feat    in   N_FEAT*FEAT_W     features, X0 in [7:0], X4 in MSBs
//  out_valid  out  1                 result valid
//  out_ready  in   1                 consumer accepts result
//  out_class  out  CLASS_W           predicted class
//  out_err    out  1                 walk aborted (depth limit)
//  busy       out  1                 state != IDLE
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. Reset clears: state=IDLE, out_valid=0,
//    out_class=0, out_err=0, busy=0, in_ready=1, node ptr=0, depth cnt=0.
//  - ROM node fields: is_leaf, leaf_class, feat_idx(3b), shift(3b), thr(FEAT_W), left, right (NODE_AW each).
//  - FSM IDLE -> WALK -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready, register in_feat, node=0, depth=0, go WALK.
//    in_valid while not IDLE is ignored (in_ready=0).
//  - WALK, per cycle, read ROM[node]:
//    - leaf: register out_class=leaf_class, out_err=0, go DONE.
//    - internal, depth==MAX_DEPTH: out_class=0, out_err=1, go DONE.
//    - internal otherwise: cmp = (feat[feat_idx] >> shift) <= thr (unsigned, zero-extended).
//      node <= cmp ? left : right; depth++.
//  - feat_idx >= N_FEAT selects feature value 0.
//  - Latency: accept at cycle 0; L internal nodes take cycles 1..L; leaf read at L+1; out_valid high from L+2.
//  - DONE: out_valid=1; out_class/out_err held stable until out_valid&&out_ready, then next edge -> IDLE.
//    No accept in the same cycle as result handoff, so the minimum period is L+3 cycles.
//  - Reset mid-walk or mid-DONE: immediate abort, result discarded, no out_valid pulse.
//  - Depth counter is ceil(log2(MAX_DEPTH+1)) bits wide and never wraps.
// STRUCTURE
//  - Package dtree_pkg: node_t packed struct (fields above), state_t enum {IDLE,WALK,DONE},
//    localparams FEAT_W, NODE_AW, CLASS_W, FIDX_W=3, SHIFT_W=3.
//  - Sub-module dtree_node_rom: combinational addr -> node_t case table, generated per trained model.
//    Unmapped addresses return is_leaf=1, leaf_class=0.
//  - Top: FSM, feature regs, mux+shifter+comparator, depth counter, output regs.
// TESTING  (test ROM: n0 = {feat0, shift1, thr11, L=1, R=2}; n1 leaf class 1; n2 leaf class 0)
//  1. Assert rst_n=0 -> out_valid=0, out_class=0, out_err=0, busy=0, in_ready=1, asynchronously (no clock edge needed).
//  2. X0=23 accepted at cycle 0 -> 23>>1=11<=11 takes the left branch; out_valid=1 at cycle 3, out_class=1.
//     X0=24 -> out_class=0.
//  3. Hold out_ready=0 for 10 cycles -> out_valid, out_class stable, in_ready=0.
//     Pulse out_ready -> IDLE, in_ready=1 next cycle.
//  4. Drive in_valid during WALK with different features -> ignored; result matches the first vector.
//  5. Self-looping ROM (n0.left=n0.right=0) -> out_valid at cycle MAX_DEPTH+2, out_err=1, out_class=0.
//  6. Drop rst_n during WALK -> no out_valid. After release, a fresh vector classifies correctly.

Source files
------------

// File: rtl/dtree_pkg.sv
// Shared types and widths for the sequential decision-tree classifier.
// Node ROM records, FSM states and small record constructors live here.
package dtree_pkg;
   localparam int FEAT_W  = 8;
   localparam int NODE_AW = 8;
   localparam int CLASS_W = 1;
   localparam int FIDX_W  = 3;
   localparam int SHIFT_W = 3;

   typedef struct packed {
      logic                is_leaf;
      logic [CLASS_W-1:0]  leaf_class;
      logic [FIDX_W-1:0]   feat_idx;
      logic [SHIFT_W-1:0]  shift;
      logic [FEAT_W-1:0]   thr;
      logic [NODE_AW-1:0]  left;
      logic [NODE_AW-1:0]  right;
   } node_t;

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   function automatic node_t make_leaf(input logic [CLASS_W-1:0] cls);
      node_t n;
      n            = '0;
      n.is_leaf    = 1'b1;
      n.leaf_class = cls;
      return n;
   endfunction

   function automatic node_t make_node(input logic [FIDX_W-1:0]  fi,
                                       input logic [SHIFT_W-1:0] sh,
                                       input logic [FEAT_W-1:0]  thr,
                                       input logic [NODE_AW-1:0] l,
                                       input logic [NODE_AW-1:0] r);
      node_t n;
      n          = '0;
      n.feat_idx = fi;
      n.shift    = sh;
      n.thr      = thr;
      n.left     = l;
      n.right    = r;
      return n;
   endfunction
endpackage

// File: rtl/dtree_node_rom.sv
// Combinational node table produced from the trained model.
// MODEL 0 is the reference tree; MODEL 1 is a self-looping tree for abort checks.
module dtree_node_rom
   import dtree_pkg::*;
#(
   parameter int MODEL = 0
) (
   input  logic [NODE_AW-1:0] addr,
   output node_t              node
);
   always_comb begin
      // Any address the trainer did not emit behaves as a class-0 leaf.
      node = make_leaf(1'b0);
      if (MODEL == 1) begin
         if (addr == 8'd0) node = make_node(3'd0, 3'd0, 8'd0, 8'd0, 8'd0);
      end else begin
         case (addr)
            8'd0:    node = make_node(3'd0, 3'd1, 8'd11, 8'd1, 8'd2);
            8'd1:    node = make_leaf(1'b1);
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree classifier: walks the node ROM one node per clock
// through a single shared feature mux, shifter and comparator.
module dtree_seq_eval
   import dtree_pkg::*;
#(
   parameter int N_FEAT    = 5,
   parameter int MAX_DEPTH = 24,
   parameter int MODEL     = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_FEAT*FEAT_W-1:0] in_feat,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CLASS_W-1:0]       out_class,
   output logic                     out_err,
   output logic                     busy
);
   localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

   state_t                   state, next_state;
   logic [N_FEAT*FEAT_W-1:0] feat;
   logic [NODE_AW-1:0]       node_ptr;
   logic [DEPTH_W-1:0]       depth;
   node_t                    nd;
   logic [FEAT_W-1:0]        sel_feat;
   logic                     cmp;
   logic                     at_limit;

   dtree_node_rom #(.MODEL(MODEL)) u_rom (
      .addr (node_ptr),
      .node (nd)
   );

   // Indices beyond the feature count read as zero.
   always_comb begin
      sel_feat = '0;
      for (int i = 0; i < N_FEAT; i++)
         if (nd.feat_idx == FIDX_W'(i)) sel_feat = feat[i*FEAT_W +: FEAT_W];
   end

   assign cmp      = (sel_feat >> nd.shift) <= nd.thr;
   assign at_limit = (depth == DEPTH_W'(MAX_DEPTH));

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (in_valid)                 next_state = WALK;
         WALK: if (nd.is_leaf || at_limit)   next_state = DONE;
         DONE: if (out_ready)                next_state = IDLE;
         default:                            next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         feat      <= '0;
         node_ptr  <= '0;
         depth     <= '0;
         out_class <= '0;
         out_err   <= 1'b0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            feat     <= in_feat;
            node_ptr <= '0;
            depth    <= '0;
         end
      end else if (state == WALK) begin
         if (nd.is_leaf) begin
            out_class <= nd.leaf_class;
            out_err   <= 1'b0;
         end else if (at_limit) begin
            out_class <= '0;
            out_err   <= 1'b1;
         end else begin
            node_ptr <= cmp ? nd.left : nd.right;
            depth    <= depth + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dtree_seq_eval.sv
// Bench for dtree_seq_eval: a reference tree instance and a self-looping instance,
// checked against a table-driven tree walk computed inside the bench.
module tb_dtree_seq_eval;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        iv_t, ir_t, ov_t, ordy_t, oc_t, oe_t, busy_t;
   logic        iv_l, ir_l, ov_l, ordy_l, oc_l, oe_l, busy_l;
   logic [39:0] if_t, if_l;

   int checks = 0;
   int errors = 0;

   dtree_seq_eval #(.MODEL(0)) u_tree (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_t), .in_ready(ir_t), .in_feat(if_t),
      .out_valid(ov_t), .out_ready(ordy_t), .out_class(oc_t), .out_err(oe_t), .busy(busy_t));

   dtree_seq_eval #(.MODEL(1)) u_loop (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_l), .in_ready(ir_l), .in_feat(if_l),
      .out_valid(ov_l), .out_ready(ordy_l), .out_class(oc_l), .out_err(oe_l), .busy(busy_l));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic s_ov(input int sel);  return sel ? ov_l : ov_t;     endfunction
   function automatic logic s_ir(input int sel);  return sel ? ir_l : ir_t;     endfunction
   function automatic logic s_oc(input int sel);  return sel ? oc_l : oc_t;     endfunction
   function automatic logic s_oe(input int sel);  return sel ? oe_l : oe_t;     endfunction
   function automatic logic s_bz(input int sel);  return sel ? busy_l : busy_t; endfunction

   task automatic drive(input int sel, input logic v, input logic [39:0] f);
      if (sel != 0) begin iv_l = v; if_l = f; end
      else          begin iv_t = v; if_t = f; end
   endtask

   task automatic set_ready(input int sel, input logic r);
      if (sel != 0) ordy_l = r; else ordy_t = r;
   endtask

   // Reference walk from the node tables, with the depth-24 abort rule.
   function automatic void model(input int sel, input logic [39:0] f,
                                 output int cls, output int err, output int lat);
      int node, depth, leaf, lc, idx, sh, thr, l, r, fv;
      node = 0; depth = 0; lat = 0; cls = 0; err = 0;
      for (int step = 0; step < 300; step++) begin
         leaf = 1; lc = 0; idx = 0; sh = 0; thr = 0; l = 0; r = 0;
         if (sel == 0) begin
            if (node == 0) begin leaf = 0; idx = 0; sh = 1; thr = 11; l = 1; r = 2; end
            else if (node == 1) lc = 1;
         end else if (node == 0) begin
            leaf = 0; idx = 0; sh = 0; thr = 0; l = 0; r = 0;
         end
         if (leaf != 0) begin cls = lc; err = 0; return; end
         if (depth == 24) begin cls = 0; err = 1; return; end
         fv   = (idx < 5) ? int'(f[idx*8 +: 8]) : 0;
         node = ((fv >> sh) <= thr) ? l : r;
         depth++;
         lat++;
      end
   endfunction

   // Accept one vector; returns at the negedge inside cycle 1.
   task automatic accept(input int sel, input logic [39:0] f);
      @(negedge clk);
      drive(sel, 1'b1, f);
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, 40'h0);
   endtask

   task automatic run(input int sel, input logic [39:0] f, input int noise, input int hold);
      int cls, err, lat, first;
      model(sel, f, cls, err, lat);
      accept(sel, f);
      check("busy_walk", s_bz(sel), 1'b1);
      check("in_ready_walk", s_ir(sel), 1'b0);
      first = -1;
      for (int cyc = 1; cyc < 100; cyc++) begin
         if (s_ov(sel)) begin first = cyc; break; end
         if (noise != 0) drive(sel, 1'b1, {$urandom(), 8'($urandom())});
         @(negedge clk);
      end
      drive(sel, 1'b0, 40'h0);
      check("latency", first, lat + 2);
      check("out_class", s_oc(sel), cls[0]);
      check("out_err", s_oe(sel), err[0]);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", s_ov(sel), 1'b1);
         check("hold_class", s_oc(sel), cls[0]);
         check("hold_in_ready", s_ir(sel), 1'b0);
      end
      set_ready(sel, 1'b1);
      @(negedge clk);
      set_ready(sel, 1'b0);
      check("handoff_valid", s_ov(sel), 1'b0);
      check("handoff_in_ready", s_ir(sel), 1'b1);
   endtask

   initial begin
      logic [39:0] f;
      int seen;
      iv_t = 0; iv_l = 0; if_t = '0; if_l = '0; ordy_t = 0; ordy_l = 0;

      // Asynchronous reset observed before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      check("rst_valid", ov_t, 1'b0);
      check("rst_class", oc_t, 1'b0);
      check("rst_err", oe_t, 1'b0);
      check("rst_busy", busy_t, 1'b0);
      check("rst_in_ready", ir_t, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      run(0, 40'd23, 0, 0);
      run(0, 40'd24, 0, 10);
      run(0, {8'd200, 8'd3, 8'd90, 8'd17, 8'd22}, 1, 2);
      run(1, 40'd5, 0, 1);
      run(1, 40'd0, 1, 0);

      for (int n = 0; n < 20; n++) begin
         f = {$urandom(), 8'($urandom())};
         if ($urandom_range(0, 1) != 0) f[7:0] = 8'($urandom_range(18, 29));
         run(0, f, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      // Asynchronous reset while a result is waiting in DONE.
      accept(0, 40'd20);
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_done", ov_t, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_done_valid", ov_t, 1'b0);
      check("rst_done_class", oc_t, 1'b0);
      check("rst_done_in_ready", ir_t, 1'b1);
      @(negedge clk) rst_n = 1'b1;

      // Reset during a long walk: the aborted walk must never produce a result.
      accept(1, 40'd9);
      repeat (4) @(negedge clk);
      check("pre_rst_busy", busy_l, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_walk_busy", busy_l, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (ov_l || busy_l) seen++;
      end
      check("no_valid_after_abort", seen, 0);
      run(1, 40'd9, 0, 0);
      run(0, 40'd22, 0, 0);
      run(0, 40'd25, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
